upsample_engine: RTL and testbench
==================================

// Module: upsample_engine
// PURPOSE
// - Nearest-neighbour 2x upsampler (unpool); the inverse of the 2x2/stride-2 max-pool stage.
// - Accepts an IN_DIM x IN_DIM raster of signed 8-bit pixels.
// - Emits a 2*IN_DIM x 2*IN_DIM raster: each pixel repeated horizontally, each row repeated vertically.
// - Output rate is up to 4x input rate, so the input side has a ready handshake.
// - The output is an unthrottled valid strobe, matching the downstream engine convention.
// PARAMETERS
// - IN_DIM   14            input map width and height, in pixels
// - OUT_DIM  2*IN_DIM      output map width and height (derived; do not override)
// PORTS
// - clk        in   1   single clock; all logic posedge
// - rst        in   1   synchronous, active-high reset
// - valid_in   in   1   pixel_in is valid this cycle
// - pixel_in   in   8   signed input pixel, raster order
// - in_ready   out  1   block can accept pixel_in this cycle; a transfer is valid_in && in_ready
// - valid_out  out  1   pixel_out is valid this cycle
// - pixel_out  out  8   signed output pixel, raster order
// - all_done   out  1   sticky; set once the full OUT_DIM x OUT_DIM frame has been emitted
// BEHAVIOUR
// - Reset: state=S_ROW_A, col=0, row=0, dup=0, out_count=0, valid_out=0, pixel_out=0, all_done=0.
//   Line buffer contents are not cleared; they are don't-care.
// - in_ready is combinational: (state==S_ROW_A && !dup).
// - S_ROW_A (first copy of each row):
//   - On transfer: buf[col]<=pixel_in, hold<=pixel_in, and next cycle valid_out=1 with pixel_out=pixel_in.
//   - dup<=1 at the same time.
//   - Cycle with dup=1: valid_out=1, pixel_out=hold, dup<=0.
//     If col==IN_DIM-1 then col<=0 and state<=S_ROW_B, else col<=col+1.
//   - dup=0 and no transfer: valid_out=0, pixel_out holds its last value.
//   - Latency is 1 cycle from transfer to first copy; the second copy follows in the next cycle.
// - S_ROW_B (second copy): in_ready=0.
//   - Every cycle valid_out=1 and pixel_out=buf[col]; each col is emitted on 2 consecutive cycles (dup toggles).
//   - This takes 2*IN_DIM back-to-back cycles.
//   - After the last one: col<=0, dup<=0, state<=S_ROW_A.
//     If row==IN_DIM-1 then row<=0, else row<=row+1.
// - The buffer read is registered (1 cycle).
//   - Issue the buf[0] read on S_ROW_A's final dup cycle so S_ROW_B streams with no bubble.
//   - The S_ROW_A to S_ROW_B boundary therefore has no idle cycle.
// - A full row pair with valid_in held high is 4*IN_DIM output cycles, with no gaps.
// - out_count increments on each valid_out.
//   - At OUT_DIM*OUT_DIM-1 it wraps to 0 and all_done<=1 on the following edge.
//   - all_done stays high until rst.
// - Next frame: the block returns to S_ROW_A/row=0 automatically and accepts a new frame immediately.
//   The out_count wrap is independent of all_done.
// - valid_in while in_ready=0 is ignored; the producer must hold pixel_in.
//   No pixel is lost or duplicated.
// - Reset mid-row: asserting rst aborts the frame.
//   valid_out=0 on the next edge; the next accepted pixel is treated as (0,0).
// - Widths:
//   - col is $clog2(IN_DIM) bits.
//   - row is $clog2(IN_DIM) bits.
//   - out_count is $clog2(OUT_DIM*OUT_DIM)+1 bits.
//   - Pixels pass through unmodified; no arithmetic on data.
// STRUCTURE
// - Shared package mp_pkg:
//   - pixel_t = logic signed [7:0]
//   - state enum {S_ROW_A, S_ROW_B}
//   - typedef for IN_DIM-derived counter widths
// - Sub-module upsample_row_buffer:
//   - IN_DIM x pixel_t simple dual-port memory
//   - 1 write port, 1 registered read port
//   - no reset on storage
// - Top contains the FSM, col/row/dup counters, hold register, output register and out_count.
// TESTING
// 1. Reset, then IN_DIM=2, pixels {1,2,3,4} with valid_in held high.
//    Expect: outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4, contiguous across each row pair.
//    Expect: all_done rises 1 cycle after the 16th output.
// 2. Negative and extreme values (IN_DIM=14): pixels -128 and 127 in alternating columns.
//    Expect: each appears as 4 output pixels in a 2x2 block, sign preserved.
// 3. Sparse input: valid_in high 1 cycle in 5.
//    Expect: in S_ROW_A, valid_out is asserted exactly 2 cycles per accepted pixel.
//    Expect: S_ROW_B is 28 contiguous cycles; the total output count is 784.
// 4. Backpressure: valid_in held high with pixel_in changing every cycle.
//    Expect: only pixels present while in_ready=1 are consumed.
//    Expect: in_ready=0 throughout S_ROW_B.
//    A scoreboard confirms the 2x2 replication.
// 5. Reset mid-frame after 100 outputs, then feed a fresh full frame.
//    Expect: valid_out=0 after rst, all_done=0.
//    Expect: the fresh frame reproduces exactly from (0,0); all_done rises after 784 outputs.
// 6. Two frames back-to-back.
//    Expect: the second frame starts with no extra cycles.
//    Expect: all_done stays 1, and out_count wraps so the second frame also totals 784.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared types for the pooling/unpooling engines: pixel format, row FSM states
// and counter widths derived from the map dimension.
package mp_pkg;

    typedef logic signed [7:0] pixel_t;

    typedef enum logic {
        S_ROW_A = 1'b0,
        S_ROW_B = 1'b1
    } state_t;

    localparam int IN_DIM_DEFAULT = 14;

    typedef logic [$clog2(IN_DIM_DEFAULT)-1:0]                  idx_t;
    typedef logic [$clog2(4*IN_DIM_DEFAULT*IN_DIM_DEFAULT):0]   count_t;

    function automatic int idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    function automatic int count_width(input int dim);
        return $clog2(4*dim*dim) + 1;
    endfunction

endpackage

// File: rtl/upsample_row_buffer.sv
// One-row line buffer: simple dual-port memory with a registered read port.
// Storage is intentionally not reset so it maps onto block RAM.
module upsample_row_buffer
    import mp_pkg::*;
#(
    parameter int DEPTH = IN_DIM_DEFAULT,
    parameter int AW    = idx_width(IN_DIM_DEFAULT)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/upsample_engine.sv
// Nearest-neighbour 2x upsampler: each input pixel is emitted twice on its row
// pass (S_ROW_A), then the buffered row is replayed twice-per-pixel (S_ROW_B).
module upsample_engine
    import mp_pkg::*;
#(
    parameter  int IN_DIM  = IN_DIM_DEFAULT,
    localparam int OUT_DIM = 2*IN_DIM
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   valid_in,
    input  pixel_t pixel_in,
    output logic   in_ready,
    output logic   valid_out,
    output pixel_t pixel_out,
    output logic   all_done
);

    localparam int IDX_W = idx_width(IN_DIM);
    localparam int CNT_W = count_width(IN_DIM);
    localparam int TOTAL = OUT_DIM*OUT_DIM;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DIM-1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL-1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   col_reg, col_next;
    logic [IDX_W-1:0]   row_reg, row_next;
    logic               dup_reg, dup_next;
    pixel_t             hold_reg, hold_next;
    logic               valid_out_reg, valid_out_next;
    pixel_t             pixel_out_reg, pixel_out_next;
    logic [CNT_W-1:0]   out_count_reg, out_count_next;
    logic               all_done_reg, all_done_next;

    logic               buf_wr_en;
    logic               buf_rd_en;
    logic [IDX_W-1:0]   buf_rd_addr;
    pixel_t             buf_rd_data;

    upsample_row_buffer #(
        .DEPTH (IN_DIM),
        .AW    (IDX_W)
    ) u_row_buffer (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (col_reg),
        .wr_data (pixel_in),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    assign in_ready  = (state_reg == S_ROW_A) && !dup_reg;
    assign valid_out = valid_out_reg;
    assign pixel_out = pixel_out_reg;
    assign all_done  = all_done_reg;

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        dup_next       = dup_reg;
        hold_next      = hold_reg;
        valid_out_next = 1'b0;
        pixel_out_next = pixel_out_reg;
        out_count_next = out_count_reg;
        all_done_next  = all_done_reg;
        buf_wr_en      = 1'b0;
        buf_rd_en      = 1'b0;
        buf_rd_addr    = col_reg;

        case (state_reg)
            S_ROW_A: begin
                if (dup_reg) begin
                    valid_out_next = 1'b1;
                    pixel_out_next = hold_reg;
                    dup_next       = 1'b0;
                    if (col_reg == LAST_IDX) begin
                        // Prefetch buf[0] now so the replay pass starts without a bubble.
                        col_next    = '0;
                        state_next  = S_ROW_B;
                        buf_rd_en   = 1'b1;
                        buf_rd_addr = '0;
                    end else begin
                        col_next = col_reg + IDX_W'(1);
                    end
                end else if (valid_in) begin
                    buf_wr_en      = 1'b1;
                    hold_next      = pixel_in;
                    valid_out_next = 1'b1;
                    pixel_out_next = pixel_in;
                    dup_next       = 1'b1;
                end
            end
            S_ROW_B: begin
                valid_out_next = 1'b1;
                pixel_out_next = buf_rd_data;
                if (!dup_reg) begin
                    dup_next = 1'b1;
                end else if (col_reg == LAST_IDX) begin
                    col_next   = '0;
                    dup_next   = 1'b0;
                    state_next = S_ROW_A;
                    row_next   = (row_reg == LAST_IDX) ? '0 : row_reg + IDX_W'(1);
                end else begin
                    // Fetch the next column one cycle ahead of its first copy.
                    dup_next    = 1'b0;
                    col_next    = col_reg + IDX_W'(1);
                    buf_rd_en   = 1'b1;
                    buf_rd_addr = col_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = S_ROW_A;
            end
        endcase

        if (valid_out_reg) begin
            if (out_count_reg == LAST_CNT) begin
                out_count_next = '0;
                all_done_next  = 1'b1;
            end else begin
                out_count_next = out_count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_ROW_A;
            col_reg       <= '0;
            row_reg       <= '0;
            dup_reg       <= 1'b0;
            hold_reg      <= '0;
            valid_out_reg <= 1'b0;
            pixel_out_reg <= '0;
            out_count_reg <= '0;
            all_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            dup_reg       <= dup_next;
            hold_reg      <= hold_next;
            valid_out_reg <= valid_out_next;
            pixel_out_reg <= pixel_out_next;
            out_count_reg <= out_count_next;
            all_done_reg  <= all_done_next;
        end
    end

endmodule

// File: tb/tb_upsample_engine.sv
// Directed bench for upsample_engine: a 2x2 instance for the hand-listed small
// frame and a 14x14 instance for full-frame, sparse, backpressure and reset cases.
module tb_upsample_engine;
    import mp_pkg::*;

    localparam int N    = 14;
    localparam int M    = 2*N;
    localparam int NPIX = N*N;
    localparam int NOUT = M*M;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 14x14 instance
    logic   rst = 1'b1;
    logic   valid_in = 1'b0;
    pixel_t pixel_in = '0;
    logic   in_ready, valid_out, all_done;
    pixel_t pixel_out;

    // 2x2 instance
    logic   rst_s = 1'b1;
    logic   valid_in_s = 1'b0;
    pixel_t pixel_in_s = '0;
    logic   in_ready_s, valid_out_s, all_done_s;
    pixel_t pixel_out_s;

    upsample_engine #(.IN_DIM(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .pixel_in  (pixel_in),
        .in_ready  (in_ready),
        .valid_out (valid_out),
        .pixel_out (pixel_out),
        .all_done  (all_done)
    );

    upsample_engine #(.IN_DIM(2)) dut_s (
        .clk       (clk),
        .rst       (rst_s),
        .valid_in  (valid_in_s),
        .pixel_in  (pixel_in_s),
        .in_ready  (in_ready_s),
        .valid_out (valid_out_s),
        .pixel_out (pixel_out_s),
        .all_done  (all_done_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output capture: value, cycle stamp and in_ready seen in the same cycle.
    int   oq[$];
    int   tq[$];
    int   rq[$];
    int   ad_rise = -1;
    int   ad_fall = 0;
    logic ad_prev = 1'b0;

    always @(negedge clk) begin
        if (valid_out) begin
            oq.push_back(int'(pixel_out));
            tq.push_back(cyc);
            rq.push_back(int'(in_ready));
        end
        if (all_done && !ad_prev) ad_rise = cyc;
        if (!all_done && ad_prev && !rst) ad_fall = ad_fall + 1;
        ad_prev <= all_done;
    end

    int   oq_s[$];
    int   tq_s[$];
    int   ad_rise_s = -1;
    logic ad_prev_s = 1'b0;

    always @(negedge clk) begin
        if (valid_out_s) begin
            oq_s.push_back(int'(pixel_out_s));
            tq_s.push_back(cyc);
        end
        if (all_done_s && !ad_prev_s) ad_rise_s = cyc;
        ad_prev_s <= all_done_s;
    end

    int img [2][N][N];

    task automatic feed_frame(input int slot, input int period, input bit churn, input bit drop);
        int idx = 0;
        int k = 0;
        while (idx < NPIX && k < 20000) begin
            valid_in = ((k % period) == 0);
            if (churn && !in_ready) pixel_in = pixel_t'($urandom);
            else                    pixel_in = pixel_t'(img[slot][idx / N][idx % N]);
            @(negedge clk);
            if (valid_in && in_ready) idx++;
            @(posedge clk);
            #1;
            k++;
        end
        if (drop) valid_in = 1'b0;
        check_value("feed_accepted", idx, NPIX);
    endtask

    task automatic wait_outputs(input int n);
        for (int k = 0; k < 5000 && oq.size() < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        oq.delete();
        tq.delete();
        rq.delete();
    endtask

    // Reference: output (R,C) is input (R/2,C/2); replay rows stream back-to-back,
    // both copies of a first-pass pixel are adjacent, and in_ready is low during replay.
    task automatic verify_frame(input string tag, input int base, input int slot);
        int nval = 0;
        int ncont = 0;
        int nrdy = 0;
        int i;
        check_value({tag, "_count"}, oq.size() - base >= NOUT ? NOUT : oq.size() - base, NOUT);
        if (oq.size() >= base + NOUT) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < M; c++) begin
                    i = base + r*M + c;
                    if (oq[i] != img[slot][r/2][c/2]) nval++;
                    if ((r % 2) == 1 && c > 0 && tq[i] != tq[i-1] + 1) ncont++;
                    if ((r % 2) == 0 && (c % 2) == 1 && tq[i] != tq[i-1] + 1) ncont++;
                    if ((r % 2) == 1 && c < M-1 && rq[i] != 0) nrdy++;
                end
            end
            check_value({tag, "_value_errors"}, nval, 0);
            check_value({tag, "_gap_errors"}, ncont, 0);
            check_value({tag, "_ready_in_replay"}, nrdy, 0);
        end
    endtask

    int small_in[4] = '{1, 2, 3, 4};
    int small_exp[16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int k;
        repeat (4) @(posedge clk);
        #1;
        rst   = 1'b0;
        rst_s = 1'b0;

        // Reset state
        check_value("rst_valid_out", int'(valid_out), 0);
        check_value("rst_pixel_out", int'(pixel_out), 0);
        check_value("rst_all_done", int'(all_done), 0);
        check_value("rst_in_ready", int'(in_ready), 1);
        check_value("rst_s_valid_out", int'(valid_out_s), 0);
        check_value("rst_s_all_done", int'(all_done_s), 0);

        // T1: 2x2 frame with valid held high
        idx = 0;
        k = 0;
        valid_in_s = 1'b1;
        while (idx < 4 && k < 200) begin
            pixel_in_s = pixel_t'(small_in[idx]);
            @(negedge clk);
            if (in_ready_s) idx++;
            @(posedge clk);
            #1;
            k++;
        end
        valid_in_s = 1'b0;
        for (int w = 0; w < 100 && oq_s.size() < 16; w++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check_value("t1_count", oq_s.size(), 16);
        if (oq_s.size() >= 16) begin
            for (int j = 0; j < 16; j++) check_value($sformatf("t1_out%0d", j), oq_s[j], small_exp[j]);
            check_value("t1_contiguous_span", tq_s[15] - tq_s[0], 15);
            check_value("t1_all_done_rise", ad_rise_s, tq_s[15] + 1);
        end
        check_value("t1_all_done_sticky", int'(all_done_s), 1);
        $display("T1 small frame: %0d outputs, all_done=%0d", oq_s.size(), all_done_s);

        // T2: alternating extremes, valid held high
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[0][r][c] = ((r + c) % 2 == 1) ? 127 : -128;
        clear_capture();
        ad_rise = -1;
        feed_frame(0, 1, 1'b0, 1'b1);
        wait_outputs(NOUT);
        repeat (2) @(posedge clk);
        #1;
        verify_frame("t2", 0, 0);
        if (oq.size() >= NOUT) begin
            check_value("t2_blk00_a", oq[0], -128);
            check_value("t2_blk00_b", oq[1], -128);
            check_value("t2_blk00_c", oq[M], -128);
            check_value("t2_blk00_d", oq[M+1], -128);
            check_value("t2_blk01_a", oq[2], 127);
            check_value("t2_blk01_d", oq[M+3], 127);
            check_value("t2_all_done_rise", ad_rise, tq[NOUT-1] + 1);
        end
        check_value("t2_all_done", int'(all_done), 1);
        $display("T2 extremes frame: %0d outputs", oq.size());

        // T3: sparse input, one valid cycle in five
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[1][r][c] = r*N + c - 98;
        clear_capture();
        feed_frame(1, 5, 1'b0, 1'b1);
        wait_outputs(NOUT);
        repeat (4) @(posedge clk);
        #1;
        check_value("t3_no_extra_outputs", oq.size(), NOUT);
        verify_frame("t3", 0, 1);
        $display("T3 sparse frame: %0d outputs", oq.size());

        // T4: valid held high, pixel_in churns whenever the block is not ready
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[0][r][c] = ((r*37 + c*11 + 5) % 256) - 128;
        clear_capture();
        feed_frame(0, 1, 1'b1, 1'b1);
        wait_outputs(NOUT);
        repeat (4) @(posedge clk);
        #1;
        check_value("t4_no_extra_outputs", oq.size(), NOUT);
        verify_frame("t4", 0, 0);
        $display("T4 backpressure frame: %0d outputs", oq.size());

        // T5: reset after 100 outputs, then a fresh frame
        clear_capture();
        valid_in = 1'b1;
        pixel_in = pixel_t'(55);
        for (int w = 0; w < 1000 && oq.size() < 100; w++) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        check_value("t5_valid_out_after_rst", int'(valid_out), 0);
        check_value("t5_pixel_out_after_rst", int'(pixel_out), 0);
        check_value("t5_all_done_after_rst", int'(all_done), 0);
        check_value("t5_in_ready_after_rst", int'(in_ready), 1);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[1][r][c] = 100 - r*N - c;
        clear_capture();
        ad_rise = -1;
        feed_frame(1, 1, 1'b0, 1'b1);
        wait_outputs(NOUT);
        repeat (2) @(posedge clk);
        #1;
        verify_frame("t5", 0, 1);
        if (oq.size() >= NOUT) check_value("t5_all_done_rise", ad_rise, tq[NOUT-1] + 1);
        check_value("t5_all_done", int'(all_done), 1);
        $display("T5 reset then fresh frame: %0d outputs", oq.size());

        // T6: two frames back-to-back
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                img[0][r][c] = c*9 - r*5;
                img[1][r][c] = r*9 - c*5;
            end
        clear_capture();
        ad_fall = 0;
        feed_frame(0, 1, 1'b0, 1'b0);
        feed_frame(1, 1, 1'b0, 1'b1);
        wait_outputs(2*NOUT);
        repeat (4) @(posedge clk);
        #1;
        check_value("t6_total_outputs", oq.size(), 2*NOUT);
        verify_frame("t6_f1", 0, 0);
        verify_frame("t6_f2", NOUT, 1);
        if (oq.size() >= 2*NOUT) check_value("t6_contiguous_span", tq[2*NOUT-1] - tq[0], 2*NOUT - 1);
        check_value("t6_all_done_high", int'(all_done), 1);
        check_value("t6_all_done_falls", ad_fall, 0);
        $display("T6 back-to-back frames: %0d outputs", oq.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
